nes_pad_responder: RTL and testbench

- Controller-side end of the NES serial pad interface: presents 8 button states as a 4021-style parallel-in/serial-out responder.
- Driven by an external reader through nes_latch and nes_clk; returns nes_data.
- Used as the on-chip pad model for bring-up and loop-back against the NES receiver path, and as a bench peer for it.
- nes_latch and nes_clk are asynchronous to clk; they are synchronised and edge-detected internally.

---
 rtl/nes_pad_responder.sv | 198 +++++++++++++++++++
 tb/tb_nes_pad_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_responder.sv
// nes_pad_responder
//
// Controller-side end of the NES serial pad interface. It behaves like a
// 4021 parallel-in/serial-out register. An external reader drives
// nes_latch and nes_clk and receives the button states back on nes_data.
// Both reader inputs are asynchronous to clk. Each one passes through a
// synchroniser chain, then a glitch filter, then a rising-edge detector.
//
// Optional feature: define NES_PAD_SNES_EN to build a 12-button, 16-bit
// SNES-style frame. In that build the upper four bits of the frame read
// back as not-pressed.
//
// Parameters:
//   SYNC_STAGES  flops in each input synchroniser chain (>= 2)
//   FILT_CYCLES  consecutive identical samples needed to accept a level (1..7)
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   buttons     active-high button states (8 bits, or 12 with NES_PAD_SNES_EN)
//   nes_latch   asynchronous latch from the reader, active high
//   nes_clk     asynchronous shift clock from the reader, rising-edge active
//   nes_data    serial data, active low (0 = pressed)
//   busy        high from latch acceptance until the last bit has shifted out
//   frame_done  one-cycle pulse when the final shift of a frame completes
//   proto_err   one-cycle pulse on a shift clock seen while idle

module nes_pad_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef NES_PAD_SNES_EN
    input  logic [11:0] buttons,
`else
    input  logic [7:0]  buttons,
`endif
    input  logic        nes_latch,
    input  logic        nes_clk,
    output logic        nes_data,
    output logic        busy,
    output logic        frame_done,
    output logic        proto_err
);

`ifdef NES_PAD_SNES_EN
    localparam int FRAME_W = 16;
    localparam int CNT_W   = 4;
`else
    localparam int FRAME_W = 8;
    localparam int CNT_W   = 3;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [2:0]       FILT_LAST = 3'(FILT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index 0 carries nes_latch and index 1 carries nes_clk. Both inputs
    // share the same conditioning path, so their latencies match exactly.
    logic [1:0]             raw;
    logic [SYNC_STAGES-1:0] sync_p0 [2];
    logic [2:0]             fcnt_p1 [2];
    logic [1:0]             lvl_p1;
    logic [1:0]             lvl_p2;
    logic                   latch_lvl;
    logic                   latch_rise;
    logic                   clk_rise;

    logic [FRAME_W-1:0]     load_val;

    state_t                 state;
    state_t                 state_nxt;
    logic [FRAME_W-1:0]     sh;
    logic [FRAME_W-1:0]     sh_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   frame_done_nxt;
    logic                   proto_err_nxt;

    assign raw = {nes_clk, nes_latch};

    // Stage p0: synchroniser chain.
    // Stage p1: glitch filter. The accepted level moves only after the
    //   synchronised input has differed from it for FILT_CYCLES samples
    //   in a row.
    // Stage p2: delayed copy of the accepted level, used for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sync_p0[i] <= '0;
                fcnt_p1[i] <= '0;
            end
            lvl_p1 <= '0;
            lvl_p2 <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_p0[i] <= {sync_p0[i][SYNC_STAGES-2:0], raw[i]};
                if (sync_p0[i][SYNC_STAGES-1] == lvl_p1[i]) begin
                    fcnt_p1[i] <= '0;
                end else if (fcnt_p1[i] == FILT_LAST) begin
                    lvl_p1[i]  <= sync_p0[i][SYNC_STAGES-1];
                    fcnt_p1[i] <= '0;
                end else begin
                    fcnt_p1[i] <= fcnt_p1[i] + 3'd1;
                end
            end
            lvl_p2 <= lvl_p1;
        end
    end

    assign latch_lvl  = lvl_p1[0];
    assign latch_rise = lvl_p1[0] & ~lvl_p2[0];
    assign clk_rise   = lvl_p1[1] & ~lvl_p2[1];

    // Serial data is active low, so the parallel load inverts the buttons.
`ifdef NES_PAD_SNES_EN
    assign load_val = {4'hF, ~buttons};
`else
    assign load_val = ~buttons;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sh         <= '1;
            cnt        <= '0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sh         <= sh_nxt;
            cnt        <= cnt_nxt;
            frame_done <= frame_done_nxt;
            proto_err  <= proto_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sh_nxt         = sh;
        cnt_nxt        = cnt;
        frame_done_nxt = 1'b0;
        proto_err_nxt  = 1'b0;
        nes_data       = 1'b1;
        busy           = 1'b0;

        case (state)
            LOAD, SHIFT: begin
                nes_data = sh[0];
                busy     = 1'b1;
            end
            DONE: nes_data = 1'b0;
            default: ;
        endcase

        // A latch edge takes priority over everything else, including a
        // shift clock arriving in the same cycle. It also abandons any
        // frame that is still in progress.
        if (latch_rise) begin
            state_nxt = LOAD;
            sh_nxt    = load_val;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clk_rise) proto_err_nxt = 1'b1;
                end
                LOAD: begin
                    // Parallel mode: the register follows the buttons for
                    // as long as the latch is held high.
                    if (latch_lvl) sh_nxt = load_val;
                    else           state_nxt = SHIFT;
                end
                SHIFT: begin
                    if (clk_rise) begin
                        sh_nxt = {1'b0, sh[FRAME_W-1:1]};
                        if (cnt == CNT_LAST) begin
                            state_nxt      = DONE;
                            frame_done_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                DONE: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nes_pad_responder.sv
// tb_nes_pad_responder
//
// Self-checking bench for nes_pad_responder in its default 8-bit NES build.
// A table of button patterns and their expected serial streams drives whole
// frames. Hand-written sequences then cover the multi-cycle corners: reset,
// an orphan clock, over-read, early re-latch, a latch/clock collision, a
// glitch, and a reset in the middle of a frame.

module tb_nes_pad_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] buttons = 8'h00;
    logic       nes_latch = 1'b0;
    logic       nes_clk = 1'b0;
    logic       nes_data;
    logic       busy;
    logic       frame_done;
    logic       proto_err;

    nes_pad_responder #(
        .SYNC_STAGES(2),
        .FILT_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buttons   (buttons),
        .nes_latch (nes_latch),
        .nes_clk   (nes_clk),
        .nes_data  (nes_data),
        .busy      (busy),
        .frame_done(frame_done),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Pulse monitors, sampled on the falling edge away from register updates.
    int   fd_pulses = 0;
    int   pe_pulses = 0;
    int   pe_cycles = 0;
    logic fd_prev = 1'b0;
    logic pe_prev = 1'b0;

    always @(negedge clk) begin
        if (frame_done && !fd_prev) fd_pulses <= fd_pulses + 1;
        if (proto_err && !pe_prev)  pe_pulses <= pe_pulses + 1;
        if (proto_err)              pe_cycles <= pe_cycles + 1;
        fd_prev <= frame_done;
        pe_prev <= proto_err;
    end

    typedef struct {
        logic [7:0] btn;
        logic [7:0] serial;   // bit k = nes_data value after the k-th shift
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clk_pulse();
        nes_clk = 1'b1;
        tick(6);
        nes_clk = 1'b0;
        tick(6);
    endtask

    task automatic latch_pulse(input logic [7:0] btn);
        buttons   = btn;
        nes_latch = 1'b1;
        tick(12);
        nes_latch = 1'b0;
        tick(6);
    endtask

    task automatic run_frame(input int idx, input logic [7:0] btn, input logic [7:0] serial);
        int fd_base;
        // While the latch is high the register follows the buttons. The
        // first half of the latch presents inverted buttons; only the final
        // value should be seen.
        buttons   = ~btn;
        nes_latch = 1'b1;
        tick(6);
        buttons = btn;
        tick(6);
        check($sformatf("v%0d_busy_load", idx), busy, 1'b1);
        check($sformatf("v%0d_bit0_load", idx), nes_data, serial[0]);
        nes_latch = 1'b0;
        tick(6);
        check($sformatf("v%0d_bit0", idx), nes_data, serial[0]);
        // Button changes after the latch must not disturb the frame.
        buttons = 8'h5A;
        for (int k = 1; k < 8; k++) begin
            clk_pulse();
            check($sformatf("v%0d_bit%0d", idx, k), nes_data, serial[k]);
        end
        fd_base = fd_pulses;
        nes_clk = 1'b1;
        tick(4);
        check($sformatf("v%0d_fd_early", idx), frame_done, 1'b0);
        tick(1);
        check($sformatf("v%0d_fd_pulse", idx), frame_done, 1'b1);
        check($sformatf("v%0d_data_done", idx), nes_data, 1'b0);
        check($sformatf("v%0d_busy_done", idx), busy, 1'b0);
        tick(1);
        check($sformatf("v%0d_fd_end", idx), frame_done, 1'b0);
        nes_clk = 1'b0;
        tick(6);
        check($sformatf("v%0d_fd_count", idx), fd_pulses - fd_base, 1);
    endtask

    initial begin
        int fd_base;
        int pe_base;
        int pe_cbase;

        vecs[0] = '{btn: 8'h91, serial: 8'h6E};
        vecs[1] = '{btn: 8'h00, serial: 8'hFF};
        vecs[2] = '{btn: 8'hFF, serial: 8'h00};
        vecs[3] = '{btn: 8'hA5, serial: 8'h5A};
        vecs[4] = '{btn: 8'h80, serial: 8'h7F};

        // Reset held for three cycles while the inputs toggle.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nes_latch = ~nes_latch;
            nes_clk   = ~nes_clk;
            buttons   = buttons + 8'h37;
            tick(1);
            check("rst_data", nes_data, 1'b1);
            check("rst_busy", busy, 1'b0);
        end
        nes_latch = 1'b0;
        nes_clk   = 1'b0;
        rst_n     = 1'b1;
        tick(10);
        check("rst_fd_none", fd_pulses, 0);
        check("rst_pe_none", pe_pulses, 0);
        check("idle_data", nes_data, 1'b1);
        check("idle_busy", busy, 1'b0);

        // Orphan clock after reset.
        pe_base  = pe_pulses;
        pe_cbase = pe_cycles;
        clk_pulse();
        check("orphan_pe_pulses", pe_pulses - pe_base, 1);
        check("orphan_pe_width", pe_cycles - pe_cbase, 1);
        check("orphan_data", nes_data, 1'b1);

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            run_frame(i, vecs[i].btn, vecs[i].serial);
        end

        // Over-read past the end of the frame.
        pe_base = pe_pulses;
        for (int i = 0; i < 4; i++) begin
            clk_pulse();
            check($sformatf("overread_data%0d", i), nes_data, 1'b0);
        end
        check("overread_pe", pe_pulses - pe_base, 0);

        // Early re-latch after three shifts.
        latch_pulse(8'h91);
        clk_pulse();
        clk_pulse();
        clk_pulse();
        fd_base = fd_pulses;
        latch_pulse(8'h02);
        check("relatch_data", nes_data, 1'b1);
        check("relatch_busy", busy, 1'b1);
        check("relatch_fd", fd_pulses - fd_base, 0);
        clk_pulse();
        check("relatch_bit1", nes_data, 1'b0);

        // Latch and clock rising in the same cycle: only the reload happens.
        pe_base   = pe_pulses;
        buttons   = 8'h01;
        nes_latch = 1'b1;
        nes_clk   = 1'b1;
        tick(12);
        nes_latch = 1'b0;
        nes_clk   = 1'b0;
        tick(6);
        check("collide_data", nes_data, 1'b0);
        check("collide_pe", pe_pulses - pe_base, 0);
        check("collide_fd", fd_pulses - fd_base, 0);

        // A one-cycle nes_clk glitch is filtered out.
        nes_clk = 1'b1;
        tick(1);
        nes_clk = 1'b0;
        tick(8);
        check("glitch_data", nes_data, 1'b0);
        clk_pulse();
        check("after_glitch_bit1", nes_data, 1'b1);

        // Reset pulsed in the middle of a frame.
        fd_base = fd_pulses;
        rst_n   = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midrst_data", nes_data, 1'b1);
        check("midrst_busy", busy, 1'b0);
        tick(3);
        check("midrst_fd", fd_pulses - fd_base, 0);
        pe_base = pe_pulses;
        clk_pulse();
        check("midrst_idle_pe", pe_pulses - pe_base, 1);
        check("midrst_idle_data", nes_data, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
